traffic_controller_param: RTL and testbench



---
 rtl/traffic_controller_param.sv | 154 +++++++++++++++
 tb/tb_traffic_controller_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_controller_param.sv
// Two-road traffic light controller: tick prescaler, phase timer with minimum
// highway green, all-red clearance and emergency pre-emption of the highway.
module traffic_controller_param #(
    parameter int CLKS_PER_TICK = 50000000,
    parameter int CNT_W         = 8,
    parameter int MIN_HG_TICKS  = 5,
    parameter int Y_TICKS       = 3,
    parameter int AR_TICKS      = 1,
    parameter int CG_TICKS      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    input  logic       emerg,
    output logic [1:0] Light_Highway,
    output logic [1:0] Light_Crossing,
    output logic [2:0] phase,
    output logic       tick
);

    localparam int PS_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLKS_PER_TICK - 1);
    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(MIN_HG_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(Y_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_TICKS - 1);
    localparam logic [CNT_W-1:0] CG_LAST = CNT_W'(CG_TICKS - 1);

    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b00;

    typedef enum logic [2:0] {
        ST_HG  = 3'd0,
        ST_HY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_CG  = 3'd3,
        ST_CY  = 3'd4,
        ST_AR2 = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [CNT_W-1:0]  tmr_q, tmr_d;

    assign tick = (ps_q == PS_LAST);

    always_comb begin
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_HG: begin
                // Timer saturates at the minimum green; emerg only blocks the exit.
                if (tick) begin
                    if (tmr_q != HG_LAST) begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end else if (sensor && !emerg) begin
                        state_d = ST_HY;
                        tmr_d   = '0;
                    end
                end
            end
            ST_HY: begin
                if (tick) begin
                    if (tmr_q == Y_LAST) begin
                        state_d = ST_AR1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            ST_AR1: begin
                if (tick) begin
                    if (tmr_q == AR_LAST) begin
                        state_d = emerg ? ST_HG : ST_CG;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            ST_CG: begin
                if (emerg) begin
                    state_d = ST_CY;
                    tmr_d   = '0;
                end else if (tick) begin
                    if (tmr_q == CG_LAST) begin
                        state_d = ST_CY;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            ST_CY: begin
                if (tick) begin
                    if (tmr_q == Y_LAST) begin
                        state_d = ST_AR2;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            ST_AR2: begin
                if (tick) begin
                    if (tmr_q == AR_LAST) begin
                        state_d = ST_HG;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_HG;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q    <= '0;
            tmr_q   <= '0;
            state_q <= ST_HG;
        end else begin
            ps_q    <= ps_d;
            tmr_q   <= tmr_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        Light_Highway  = LAMP_RED;
        Light_Crossing = LAMP_RED;
        phase          = state_q;
        case (state_q)
            ST_HG:   Light_Highway  = LAMP_GREEN;
            ST_HY:   Light_Highway  = LAMP_YELLOW;
            ST_CG:   Light_Crossing = LAMP_GREEN;
            ST_CY:   Light_Crossing = LAMP_YELLOW;
            default: begin
                Light_Highway  = LAMP_RED;
                Light_Crossing = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_controller_param.sv
// Directed bench for traffic_controller_param with CLKS_PER_TICK=4.
// cyc counts clk edges since the last reset edge; a tick is consumed at edges 4,8,...
module tb_traffic_controller_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] Light_Highway;
    logic [1:0] Light_Crossing;
    logic [2:0] phase;
    logic       tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;
    logic no_cg  = 1'b0;

    traffic_controller_param #(
        .CLKS_PER_TICK(4),
        .CNT_W(8),
        .MIN_HG_TICKS(5),
        .Y_TICKS(3),
        .AR_TICKS(1),
        .CG_TICKS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sensor(sensor),
        .emerg(emerg),
        .Light_Highway(Light_Highway),
        .Light_Crossing(Light_Crossing),
        .phase(phase),
        .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Per-cycle checks: lamp safety, tick cadence, crossing-green ban when armed.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (Light_Highway != 2'b00 && Light_Crossing != 2'b00) begin
                bad++;
                $display("FAIL invariant cyc=%0d hw=%b cr=%b", cyc, Light_Highway, Light_Crossing);
            end
            total++;
            if (tick !== ((cyc % 4) == 3)) begin
                bad++;
                $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, ((cyc % 4) == 3));
            end
            if (no_cg) begin
                total++;
                if (Light_Crossing == 2'b10) begin
                    bad++;
                    $display("FAIL no_cg cyc=%0d cr=%b", cyc, Light_Crossing);
                end
            end
        end
    end

    typedef struct {
        logic       rst_first;
        int         cyc;
        logic       sensor;
        logic       emerg;
        logic       nocg;
        logic [2:0] ph;
        logic [1:0] hw;
        logic [1:0] cr;
    } vec_t;

    vec_t vq[$];

    task automatic chk_out(string name, logic [2:0] ph, logic [1:0] hw, logic [1:0] cr);
        total++;
        if (phase !== ph || Light_Highway !== hw || Light_Crossing !== cr) begin
            bad++;
            $display("FAIL %s cyc=%0d got ph=%0d hw=%b cr=%b want ph=%0d hw=%b cr=%b",
                     name, cyc, phase, Light_Highway, Light_Crossing, ph, hw, cr);
        end
    endtask

    task automatic chk_bit(string name, logic got, logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sensor = 1'b0;
        emerg = 1'b0;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk_out("reset_state", 3'd0, 2'b10, 2'b00);
        chk_bit("reset_tick", tick, 1'b0);
    endtask

    task automatic run_to(int c);
        int guard = 0;
        while (cyc < c && guard < 10000) begin
            step();
            guard++;
        end
        total++;
        if (cyc != c) begin
            bad++;
            $display("FAIL run_to got=%0d want=%0d", cyc, c);
        end
    endtask

    task automatic add(logic r, int c, logic s, logic e, logic n,
                       logic [2:0] ph, logic [1:0] hw, logic [1:0] cr);
        vec_t v;
        v.rst_first = r; v.cyc = c; v.sensor = s; v.emerg = e; v.nocg = n;
        v.ph = ph; v.hw = hw; v.cr = cr;
        vq.push_back(v);
    endtask

    initial begin
        // Idle with sensor low.
        add(1, 0,   0, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 100, 0, 0, 0, 3'd0, 2'b10, 2'b00);
        // Sensor held from reset release: full cycle.
        add(1, 0,   1, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 19,  1, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 20,  1, 0, 0, 3'd1, 2'b01, 2'b00);
        add(0, 31,  1, 0, 0, 3'd1, 2'b01, 2'b00);
        add(0, 32,  1, 0, 0, 3'd2, 2'b00, 2'b00);
        add(0, 35,  1, 0, 0, 3'd2, 2'b00, 2'b00);
        add(0, 36,  1, 0, 0, 3'd3, 2'b00, 2'b10);
        add(0, 75,  1, 0, 0, 3'd3, 2'b00, 2'b10);
        add(0, 76,  1, 0, 0, 3'd4, 2'b00, 2'b01);
        add(0, 87,  1, 0, 0, 3'd4, 2'b00, 2'b01);
        add(0, 88,  1, 0, 0, 3'd5, 2'b00, 2'b00);
        add(0, 91,  1, 0, 0, 3'd5, 2'b00, 2'b00);
        add(0, 92,  1, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 111, 1, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 112, 1, 0, 0, 3'd1, 2'b01, 2'b00);
        // Emergency raised mid-tick in CG, then held in HG with sensor high.
        add(1, 0,   1, 0, 0, 3'd0, 2'b10, 2'b00);
        add(0, 50,  1, 1, 0, 3'd3, 2'b00, 2'b10);
        add(0, 51,  1, 1, 0, 3'd4, 2'b00, 2'b01);
        add(0, 59,  1, 1, 0, 3'd4, 2'b00, 2'b01);
        add(0, 60,  1, 1, 0, 3'd5, 2'b00, 2'b00);
        add(0, 63,  1, 1, 0, 3'd5, 2'b00, 2'b00);
        add(0, 64,  1, 1, 0, 3'd0, 2'b10, 2'b00);
        add(0, 130, 1, 1, 0, 3'd0, 2'b10, 2'b00);
        // Emergency raised in HY: crossing green skipped.
        add(1, 0,   1, 0, 1, 3'd0, 2'b10, 2'b00);
        add(0, 20,  1, 1, 1, 3'd1, 2'b01, 2'b00);
        add(0, 31,  1, 1, 1, 3'd1, 2'b01, 2'b00);
        add(0, 32,  1, 1, 1, 3'd2, 2'b00, 2'b00);
        add(0, 35,  1, 1, 1, 3'd2, 2'b00, 2'b00);
        add(0, 36,  1, 1, 1, 3'd0, 2'b10, 2'b00);
        add(0, 100, 1, 1, 1, 3'd0, 2'b10, 2'b00);

        foreach (vq[i]) begin
            if (vq[i].rst_first) reset_dut();
            run_to(vq[i].cyc);
            chk_out($sformatf("vec%0d_c%0d", i, vq[i].cyc), vq[i].ph, vq[i].hw, vq[i].cr);
            sensor = vq[i].sensor;
            emerg  = vq[i].emerg;
            no_cg  = vq[i].nocg;
        end
        no_cg = 1'b0;

        // Sensor only on non-tick edges: never leaves HG.
        reset_dut();
        while (cyc < 120) begin
            sensor = ((cyc % 4) != 3);
            step();
            chk_out("nontick_sensor", 3'd0, 2'b10, 2'b00);
        end

        // Sensor on tick 3 only: min green not reached.
        reset_dut();
        while (cyc < 40) begin
            sensor = (cyc == 11);
            step();
            chk_out("early_sensor", 3'd0, 2'b10, 2'b00);
        end

        // One-cycle sensor coinciding with tick 6.
        reset_dut();
        run_to(23);
        sensor = 1'b1;
        chk_out("tick6_before", 3'd0, 2'b10, 2'b00);
        step();
        sensor = 1'b0;
        chk_out("tick6_hy", 3'd1, 2'b01, 2'b00);

        // Reset pulse in the middle of CG.
        reset_dut();
        sensor = 1'b1;
        run_to(50);
        chk_out("midcg_before", 3'd3, 2'b00, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sensor = 1'b0;
        chk_out("midcg_reset", 3'd0, 2'b10, 2'b00);
        chk_bit("midcg_tick0", tick, 1'b0);
        step(); step();
        chk_bit("midcg_tick2", tick, 1'b0);
        step();
        chk_bit("midcg_tick3", tick, 1'b1);
        step();
        chk_bit("midcg_tick4", tick, 1'b0);
        chk_out("midcg_after", 3'd0, 2'b10, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
